// File: rtl/th_pkg.sv
// Shared definitions for the test-harness telemetry transmitter:
// FSM state encoding, header marker default and frame geometry.
package th_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_GAP     = 3'd3,
    ST_CSUM    = 3'd4
  } th_state_t;

  localparam logic [3:0] HDR_MARK_DEFAULT = 4'hA;
  localparam int         PAYLOAD_BYTES    = 6;
  localparam int         WORD_W           = 48;

endpackage

// File: rtl/th_rr_arbiter.sv
// Combinational round-robin pick: searches the request vector starting at
// rr_ptr, wrapping at N_SRC, and reports the first requester found.
module th_rr_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  input  logic [1:0]       rr_ptr,
  output logic [1:0]       grant,
  output logic             valid
);

  // First requester at or above rr_ptr, wrapping around to index 0
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 0; off < N_SRC; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/test_harness_tx_arbiter.sv
// Shares the 8-bit logic-analyzer tap between up to four 48-bit telemetry
// sources. Each frame: header {HDR_MARK, id, seq}, then six payload bytes
// LSB-first with STROBE high, then GAP_CYCLES idle cycles.
// Optional build macro TH_TX_CHECKSUM_EN appends an XOR checksum byte.
module test_harness_tx_arbiter
  import th_pkg::*;
#(
  parameter int         N_SRC      = 4,
  parameter int         GAP_CYCLES = 2,
  parameter logic [3:0] HDR_MARK   = HDR_MARK_DEFAULT
) (
  input  logic                    CLK_1MHZ,
  input  logic                    RESET,
  input  logic [N_SRC-1:0]        REQ,
  input  logic [WORD_W*N_SRC-1:0] SRC_DATA,
  output logic [N_SRC-1:0]        ACK,
  output logic [7:0]              D,
  output logic                    STROBE,
  output logic                    BUSY
);

  th_state_t         state;
  logic [1:0]        rr_ptr;
  logic [1:0]        seq;
  logic [1:0]        grant_q;
  logic [WORD_W-1:0] buffer;
  logic [3:0]        cnt;
  logic [1:0]        arb_grant;
  logic              arb_valid;
  logic              arb_window;
`ifdef TH_TX_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  th_rr_arbiter #(.N_SRC(N_SRC)) u_arb (
    .req    (REQ),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  // Arbitration happens in IDLE and on the edge that leaves GAP
  assign arb_window = (state == ST_IDLE) ||
                      ((state == ST_GAP) && (cnt == 4'(GAP_CYCLES)));

  // Frame sequencer: grant, header, payload shift-out, optional checksum, gap
  always_ff @(posedge CLK_1MHZ or negedge RESET) begin
    if (!RESET) begin
      // NOTE: all state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order. The word
      // buffer is reset too, so a reset never leaks stale telemetry.
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      seq     <= '0;
      grant_q <= '0;
      buffer  <= '0;
      cnt     <= '0;
      ACK     <= '0;
      D       <= '0;
      STROBE  <= 1'b0;
      BUSY    <= 1'b0;
`ifdef TH_TX_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      ACK <= '0;
      if (arb_window) begin
        if (arb_valid) begin
          buffer         <= SRC_DATA[WORD_W*arb_grant +: WORD_W];
          ACK[arb_grant] <= 1'b1;
          D              <= {HDR_MARK, arb_grant, seq};
          STROBE         <= 1'b1;
          BUSY           <= 1'b1;
          grant_q        <= arb_grant;
          state          <= ST_HDR;
`ifdef TH_TX_CHECKSUM_EN
          csum           <= {HDR_MARK, arb_grant, seq};
`endif
        end else begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      end else begin
        unique case (state)
          ST_HDR: begin
            D      <= buffer[7:0];
            buffer <= buffer >> 8;
            cnt    <= 4'd1;
            state  <= ST_PAYLOAD;
`ifdef TH_TX_CHECKSUM_EN
            csum   <= csum ^ buffer[7:0];
`endif
          end
          ST_PAYLOAD: begin
            if (cnt != 4'(PAYLOAD_BYTES)) begin
              D      <= buffer[7:0];
              buffer <= buffer >> 8;
              cnt    <= cnt + 4'd1;
`ifdef TH_TX_CHECKSUM_EN
              csum   <= csum ^ buffer[7:0];
`endif
            end else begin
`ifdef TH_TX_CHECKSUM_EN
              D      <= csum;
              state  <= ST_CSUM;
`else
              D      <= '0;
              STROBE <= 1'b0;
              rr_ptr <= (grant_q == 2'(N_SRC-1)) ? 2'd0 : grant_q + 2'd1;
              seq    <= seq + 2'd1;
              cnt    <= 4'd1;
              BUSY   <= (GAP_CYCLES != 0);
              state  <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
`endif
            end
          end
`ifdef TH_TX_CHECKSUM_EN
          ST_CSUM: begin
            D      <= '0;
            STROBE <= 1'b0;
            rr_ptr <= (grant_q == 2'(N_SRC-1)) ? 2'd0 : grant_q + 2'd1;
            seq    <= seq + 2'd1;
            cnt    <= 4'd1;
            BUSY   <= (GAP_CYCLES != 0);
            state  <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
`endif
          ST_GAP: begin
            cnt <= cnt + 4'd1;
          end
          default: begin
            state  <= ST_IDLE;
            D      <= '0;
            STROBE <= 1'b0;
            BUSY   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_harness_tx_arbiter.sv
// Self-checking bench for test_harness_tx_arbiter: a frame-schedule model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized request phase.
module tb_test_harness_tx_arbiter;
  import th_pkg::*;

  localparam int         N_SRC      = 4;
  localparam int         GAP_CYCLES = 2;
  localparam logic [3:0] MARK       = 4'hA;
`ifdef TH_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 8;
`else
  localparam int FRAME_LEN = 7;
`endif

  logic                  CLK_1MHZ = 1'b0;
  logic                  RESET    = 1'b0;
  logic [N_SRC-1:0]      REQ      = '0;
  logic [48*N_SRC-1:0]   SRC_DATA = '0;
  logic [N_SRC-1:0]      ACK;
  logic [7:0]            D;
  logic                  STROBE;
  logic                  BUSY;

  int total = 0;
  int bad   = 0;

  test_harness_tx_arbiter #(
    .N_SRC      (N_SRC),
    .GAP_CYCLES (GAP_CYCLES),
    .HDR_MARK   (MARK)
  ) dut (
    .CLK_1MHZ (CLK_1MHZ),
    .RESET    (RESET),
    .REQ      (REQ),
    .SRC_DATA (SRC_DATA),
    .ACK      (ACK),
    .D        (D),
    .STROBE   (STROBE),
    .BUSY     (BUSY)
  );

  always #500 CLK_1MHZ = ~CLK_1MHZ;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: per-frame output schedule ----------
  typedef struct packed {
    logic [7:0] d;
    logic       stb;
    logic       busy;
  } slot_t;

  slot_t            sched[$];
  logic [7:0]       exp_d    = '0;
  logic             exp_stb  = 1'b0;
  logic             exp_busy = 1'b0;
  logic [N_SRC-1:0] exp_ack  = '0;
  int               m_ptr    = 0;
  int               m_seq    = 0;

  always @(posedge CLK_1MHZ or negedge RESET) begin
    int         g;
    logic [47:0] w;
    logic [7:0]  hdr;
    logic [7:0]  x;
    slot_t       s;
    if (!RESET) begin
      sched.delete();
      m_ptr = 0; m_seq = 0;
      exp_d = '0; exp_stb = 1'b0; exp_busy = 1'b0; exp_ack = '0;
    end else begin
      exp_ack = '0;
      if (sched.size() == 0) begin
        g = -1;
        for (int k = 0; k < N_SRC; k++)
          if (g < 0 && REQ[(m_ptr + k) % N_SRC]) g = (m_ptr + k) % N_SRC;
        if (g >= 0) begin
          w   = SRC_DATA[48*g +: 48];
          hdr = {MARK, 2'(g), 2'(m_seq)};
          exp_ack[g] = 1'b1;
          sched.push_back('{d: hdr, stb: 1'b1, busy: 1'b1});
          x = hdr;
          for (int b = 0; b < 6; b++) begin
            sched.push_back('{d: w[8*b +: 8], stb: 1'b1, busy: 1'b1});
            x = x ^ w[8*b +: 8];
          end
`ifdef TH_TX_CHECKSUM_EN
          sched.push_back('{d: x, stb: 1'b1, busy: 1'b1});
`endif
          if (GAP_CYCLES == 0) sched.push_back('{d: 8'h00, stb: 1'b0, busy: 1'b0});
          for (int k = 0; k < GAP_CYCLES; k++)
            sched.push_back('{d: 8'h00, stb: 1'b0, busy: 1'b1});
          m_ptr = (g + 1) % N_SRC;
          m_seq = (m_seq + 1) % 4;
        end
      end
      if (sched.size() > 0) begin
        s = sched.pop_front();
        exp_d = s.d; exp_stb = s.stb; exp_busy = s.busy;
      end else begin
        exp_d = '0; exp_stb = 1'b0; exp_busy = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge CLK_1MHZ) begin
    check("D", D, exp_d);
    check("STROBE", STROBE, exp_stb);
    check("BUSY", BUSY, exp_busy);
    check("ACK", ACK, exp_ack);
  end

  // ---------------- frame monitor for directed scenarios -------------------
  logic [7:0] hdr_q[$];
  logic [7:0] byte_q[$];
  int         ack_cnt  = 0;
  logic       prev_stb = 1'b0;

  always @(negedge CLK_1MHZ) begin
    if (STROBE && !prev_stb) hdr_q.push_back(D);
    if (STROBE) byte_q.push_back(D);
    if (|ACK) ack_cnt++;
    prev_stb = STROBE;
  end

  task automatic tick();
    @(negedge CLK_1MHZ);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b0;
    REQ   = '0;
    repeat (2) tick();
    RESET = 1'b1;
    hdr_q.delete();
    byte_q.delete();
    ack_cnt = 0;
  endtask

  task automatic wait_hdrs(input int n);
    int c;
    c = 0;
    while (hdr_q.size() < n && c < 200) begin
      tick();
      c++;
    end
    check("header_wait", 64'(hdr_q.size() >= n), 64'd1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (BUSY && c < 100) begin
      tick();
      c++;
    end
    check("idle_wait", BUSY, 1'b0);
  endtask

  initial begin
    #30_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] w1;
    logic [63:0] r;

    // Reset values while RESET is held low
    RESET = 1'b0;
    repeat (3) tick();
    check("rst_D", D, 8'h00);
    check("rst_STROBE", STROBE, 1'b0);
    check("rst_BUSY", BUSY, 1'b0);
    check("rst_ACK", ACK, 4'b0000);
    RESET = 1'b1;
    tick();

    // Single source: header A0, bytes 01..06, then two gap cycles
    SRC_DATA[47:0] = 48'h0605_0403_0201;
    REQ = 4'b0001;
    tick();
    check("single_ack", ACK, 4'b0001);
    check("single_hdr", D, 8'hA0);
    check("single_hdr_stb", STROBE, 1'b1);
    REQ = 4'b0000;
    for (int b = 1; b <= 6; b++) begin
      tick();
      check("single_byte", D, 64'(b));
      check("single_byte_stb", STROBE, 1'b1);
    end
`ifdef TH_TX_CHECKSUM_EN
    tick();
    check("csum_byte", D, 8'hA7);
    check("csum_stb", STROBE, 1'b1);
`endif
    for (int k = 0; k < 2; k++) begin
      tick();
      check("gap_D", D, 8'h00);
      check("gap_STROBE", STROBE, 1'b0);
      check("gap_BUSY", BUSY, 1'b1);
    end
    tick();
    check("after_gap_BUSY", BUSY, 1'b0);

    // Contention: all four held; grants 0,1,2,3,0 with seq 0,1,2,3,0
    apply_reset();
    for (int i = 0; i < N_SRC; i++) begin
      r = {$urandom, $urandom};
      SRC_DATA[48*i +: 48] = r[47:0];
    end
    REQ = 4'b1111;
    wait_hdrs(5);
    REQ = 4'b0000;
    check("cont_hdr0", hdr_q[0], 8'hA0);
    check("cont_hdr1", hdr_q[1], 8'hA5);
    check("cont_hdr2", hdr_q[2], 8'hAA);
    check("cont_hdr3", hdr_q[3], 8'hAF);
    check("cont_hdr4", hdr_q[4], 8'hA0);
    wait_idle();

    // Pointer fairness: src2 granted, then 0101 -> src0 wins (search from 3)
    apply_reset();
    REQ = 4'b0100;
    wait_hdrs(1);
    check("fair_hdr_src2", hdr_q[0], 8'hA8);
    REQ = 4'b0101;
    wait_hdrs(2);
    REQ = 4'b0000;
    check("fair_hdr_src0", hdr_q[1], 8'hA1);
    wait_idle();

    // Reset mid-frame after the 3rd payload byte
    apply_reset();
    SRC_DATA[47:0] = 48'h1111_2222_3333;
    REQ = 4'b0001;
    wait_hdrs(1);
    REQ = 4'b0000;
    repeat (3) tick();
    #200;
    RESET = 1'b0;
    #1;
    check("midrst_D", D, 8'h00);
    check("midrst_STROBE", STROBE, 1'b0);
    check("midrst_BUSY", BUSY, 1'b0);
    tick();
    RESET = 1'b1;
    hdr_q.delete();
    byte_q.delete();
    REQ = 4'b0010;
    wait_hdrs(1);
    REQ = 4'b0000;
    check("postrst_hdr", hdr_q[0], 8'hA4);
    wait_idle();

    // Request drop and data change mid-frame: latched word is emitted, one ACK
    apply_reset();
    w1 = 48'h5A4B_3C2D_1E0F;
    SRC_DATA[47:0] = w1;
    REQ = 4'b0001;
    wait_hdrs(1);
    tick();
    tick();
    REQ = 4'b0000;
    SRC_DATA[47:0] = 48'hFFFF_FFFF_FFFF;
    wait_idle();
    repeat (3) tick();
    check("stab_len", 64'(byte_q.size()), 64'(FRAME_LEN));
    for (int b = 0; b < 6; b++)
      check("stab_byte", byte_q[1 + b], w1[8*b +: 8]);
    check("stab_acks", 64'(ack_cnt), 64'd1);

    // Randomized requesters; the per-cycle compare checks every frame
    apply_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      for (int i = 0; i < N_SRC; i++) begin
        if (ACK[i]) begin
          if ($urandom_range(1, 0) == 0) REQ[i] = 1'b0;
        end else if (!REQ[i] && $urandom_range(3, 0) == 0) begin
          r = {$urandom, $urandom};
          SRC_DATA[48*i +: 48] = r[47:0];
          REQ[i] = 1'b1;
        end
      end
    end
    REQ = '0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
